// File: rtl/vga_plot_arbiter_pkg.sv
// vga_plot_arbiter_pkg: screen geometry defaults, colour width, requester roles and FSM state type.
package vga_plot_arbiter_pkg;
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int COLOUR_W     = 24;
    // requester index assignments
    localparam int REQ_NOTE_DRAWER = 0;
    localparam int REQ_RESET_SCREEN = 1;
    localparam int REQ_BG_SCANNER  = 2;
    typedef enum logic {IDLE, LOCKED} state_e;
endpackage

// File: rtl/vga_plot_arbiter_arb_picker.sv
// arb_picker: combinational winner search over the valid vector, starting just after the pointer and wrapping.
module arb_picker #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [1:0]         ptr_i,
    output logic [1:0]         winner_o,
    output logic               any_valid_o
);
    function automatic int idx(input logic [1:0] p, input int k);
        int s = int'(p) + 1 + k;
        return s >= NUM_REQ ? s - NUM_REQ : s;
    endfunction

    // walk from farthest to nearest so the nearest valid requester is written last
    always_comb begin
        winner_o = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (valid_i[idx(ptr_i, k)]) winner_o = 2'(idx(ptr_i, k));
    end

    assign any_valid_o = |valid_i;
endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: locks one pixel requester onto the vga_adapter plot port per burst.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise index 0 has highest priority.
module vga_plot_arbiter
    import vga_plot_arbiter_pkg::*;
#(
    parameter int          NUM_REQ   = 3,
    parameter logic [15:0] MAX_BURST = 16'd0,
    parameter int          SCREEN_W  = SCREEN_W_DEF,
    parameter int          SCREEN_H  = SCREEN_H_DEF
) (
    input  logic                        CLOCK_50,
    input  logic                        resetn,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [8*NUM_REQ-1:0]        req_x,
    input  logic [8*NUM_REQ-1:0]        req_y,
    input  logic [COLOUR_W*NUM_REQ-1:0] req_colour,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        plot,
    output logic [7:0]                  screenX,
    output logic [7:0]                  screenY,
    output logic [COLOUR_W-1:0]         colour,
    output logic [1:0]                  owner,
    output logic                        busy
);
    state_e                state_q, state_d;
    logic [1:0]            owner_q, owner_d, winner, ptr;
    logic [15:0]           cnt_q, cnt_d;
    logic                  plot_q, plot_d;
    logic [7:0]            x_q, x_d, y_q, y_d, sel_x, sel_y;
    logic [COLOUR_W-1:0]   col_q, col_d, sel_col;
    logic                  any_valid, accept, at_limit;

    arb_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .valid_i    (req_valid),
        .ptr_i      (ptr),
        .winner_o   (winner),
        .any_valid_o(any_valid)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q;
    always_ff @(posedge CLOCK_50)
        if (!resetn) ptr_q <= 2'(NUM_REQ - 1);
        else if (state_q == IDLE && any_valid) ptr_q <= winner;
    assign ptr = ptr_q;
`else
    // pointer pinned at the top index makes the search start at 0: plain fixed priority
    assign ptr = 2'(NUM_REQ - 1);
`endif

    assign sel_x    = req_x[8*owner_q +: 8];
    assign sel_y    = req_y[8*owner_q +: 8];
    assign sel_col  = req_colour[COLOUR_W*owner_q +: COLOUR_W];
    assign accept   = state_q == LOCKED && req_valid[owner_q];
    assign at_limit = MAX_BURST != 16'd0 && cnt_q + 16'd1 == MAX_BURST;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        plot_d  = 1'b0;
        if (state_q == IDLE) begin
            if (any_valid) begin
                state_d = LOCKED;
                owner_d = winner;
                cnt_d   = '0;
            end
        end else if (accept) begin
            x_d    = sel_x;
            y_d    = sel_y;
            col_d  = sel_col;
            // off-screen pixels are consumed but never strobed
            plot_d = (32'(sel_x) < SCREEN_W) && (32'(sel_y) < SCREEN_H);
            cnt_d  = cnt_q + 16'd1;
            state_d = (req_last[owner_q] || at_limit) ? IDLE : LOCKED;
        end
    end

    always_ff @(posedge CLOCK_50)
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= '0;
            cnt_q   <= '0;
            plot_q  <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            plot_q  <= plot_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
        end

    assign busy    = state_q == LOCKED;
    assign grant   = busy ? {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q : '0;
    assign plot    = plot_q;
    assign screenX = x_q;
    assign screenY = y_q;
    assign colour  = col_q;
    assign owner   = owner_q;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed and random checks of two arbiters (unlimited and 4-pixel bursts) against a transaction model.
module tb_vga_plot_arbiter;
    localparam int N = 3;
    localparam int SW = 160;
    localparam int SH = 120;

    logic clk = 1'b0, resetn = 1'b0;
    logic [N-1:0] rv = '0, rl = '0;
    logic [8*N-1:0] rx = '0, ry = '0;
    logic [24*N-1:0] rc = '0;
    logic [N-1:0] grant_a, grant_b;
    logic plot_a, plot_b, busy_a, busy_b;
    logic [7:0] x_a, y_a, x_b, y_b;
    logic [23:0] c_a, c_b;
    logic [1:0] own_a, own_b;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    vga_plot_arbiter #(.NUM_REQ(N)) dut_a (
        .CLOCK_50(clk), .resetn(resetn), .req_valid(rv), .req_last(rl),
        .req_x(rx), .req_y(ry), .req_colour(rc), .grant(grant_a), .plot(plot_a),
        .screenX(x_a), .screenY(y_a), .colour(c_a), .owner(own_a), .busy(busy_a));

    vga_plot_arbiter #(.NUM_REQ(N), .MAX_BURST(16'd4)) dut_b (
        .CLOCK_50(clk), .resetn(resetn), .req_valid(rv), .req_last(rl),
        .req_x(rx), .req_y(ry), .req_colour(rc), .grant(grant_b), .plot(plot_b),
        .screenX(x_b), .screenY(y_b), .colour(c_b), .owner(own_b), .busy(busy_b));

    // transaction model: one entry per instance, index 1 has a 4-pixel burst limit
    int lim [2] = '{0, 4};
    bit m_lock [2], m_plot [2], m_acc [2];
    int m_own [2], m_cnt [2], m_ptr [2];
    logic [7:0] m_x [2], m_y [2];
    logic [23:0] m_c [2];
    int rem [N];

    function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
`else
        for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
        return 0;
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0;
            m_plot[k] = 0;
            if (!resetn) begin
                m_lock[k] = 0; m_own[k] = 0; m_cnt[k] = 0; m_ptr[k] = N - 1;
                m_x[k] = 0; m_y[k] = 0; m_c[k] = 0;
            end else if (!m_lock[k]) begin
                if (rv != 0) begin
                    m_own[k] = pick(rv, m_ptr[k]);
                    m_ptr[k] = m_own[k];
                    m_lock[k] = 1;
                    m_cnt[k] = 0;
                end
            end else if (rv[m_own[k]]) begin
                m_acc[k] = 1;
                m_x[k] = rx[8*m_own[k] +: 8];
                m_y[k] = ry[8*m_own[k] +: 8];
                m_c[k] = rc[24*m_own[k] +: 24];
                m_plot[k] = m_x[k] < SW && m_y[k] < SH;
                m_cnt[k]++;
                if (rl[m_own[k]] || (lim[k] != 0 && m_cnt[k] == lim[k])) m_lock[k] = 0;
            end
        end
    endtask

    function automatic logic [46:0] exp_vec(input int k);
        return {m_lock[k] ? 3'(1 << m_own[k]) : 3'b0, m_plot[k], 2'(m_own[k]), m_lock[k], m_x[k], m_y[k], m_c[k]};
    endfunction

    function automatic logic [46:0] got(input int k);
        return k == 0 ? {grant_a, plot_a, own_a, busy_a, x_a, y_a, c_a}
                      : {grant_b, plot_b, own_b, busy_b, x_b, y_b, c_b};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_pix(input int i, input int x, input int y, input logic [23:0] c);
        rx[8*i +: 8] = 8'(x);
        ry[8*i +: 8] = 8'(y);
        rc[24*i +: 24] = c;
    endtask

    task automatic rand_pix();
        for (int i = 0; i < N; i++) set_pix(i, $urandom_range(0, SW - 1), $urandom_range(0, SH - 1), 24'($urandom));
    endtask

    task automatic do_reset();
        resetn = 1'b0; rv = '0; rl = '0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; rv = 3'b111; rl = 3'b000; rand_pix();
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got(k) !== 47'd0) begin errors++; $display("FAIL reset dut%0d got=%h exp=0", k, got(k)); end
            checks++;
            if (got(k) !== exp_vec(k)) begin errors++; $display("FAIL reset_model dut%0d got=%h exp=%h", k, got(k), exp_vec(k)); end
        end
        rv = '0;
    endtask

    task automatic test_single();
        do_reset();
        rv = 3'b001; rl = 3'b001; set_pix(0, 10, 20, 24'hFF0000);
        tick();
        checks++;
        if (grant_a !== 3'b001 || plot_a !== 1'b0) begin errors++; $display("FAIL single_grant got=%b/%b exp=001/0", grant_a, plot_a); end
        tick();
        rv = '0; rl = '0;
        checks++;
        if ({plot_a, x_a, y_a, c_a, busy_a, grant_a} !== {1'b1, 8'd10, 8'd20, 24'hFF0000, 1'b0, 3'b000}) begin
            errors++; $display("FAIL single_plot got=%b %0d %0d %h %b %b exp=1 10 20 ff0000 0 000", plot_a, x_a, y_a, c_a, busy_a, grant_a);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got(k) !== exp_vec(k)) begin errors++; $display("FAIL single_model dut%0d got=%h exp=%h", k, got(k), exp_vec(k)); end
        end
    endtask

    task automatic test_fixed_priority();
        int n1 = 0;
        bit seen = 0;
        do_reset();
        rem = '{0, 3, 3};
        for (int c = 0; c < 20 && !seen; c++) begin
            for (int i = 0; i < N; i++) begin rv[i] = rem[i] > 0; rl[i] = rem[i] == 1; end
            rand_pix();
            tick();
            if (m_acc[0]) rem[m_own[0]]--;
            if (plot_a && own_a == 2'd1) n1++;
            if (grant_a == 3'b100) begin
                seen = 1;
                checks++;
                if (n1 !== 3) begin errors++; $display("FAIL priority_burst got=%0d exp=3 plots before grant 100", n1); end
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got(k) !== exp_vec(k)) begin errors++; $display("FAIL priority_model dut%0d got=%h exp=%h", k, got(k), exp_vec(k)); end
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL priority_timeout got=no grant 100 exp=grant 100"); end
        rv = '0; rl = '0;
    endtask

    task automatic test_grant_seq();
`ifdef ARB_ROUND_ROBIN_EN
        logic [2:0] exp_g [8] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
`else
        logic [2:0] exp_g [8] = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
`endif
        do_reset();
        rv = 3'b111; rl = 3'b111;
        for (int c = 0; c < 8; c++) begin
            rand_pix();
            tick();
            checks++;
            if (grant_a !== exp_g[c]) begin errors++; $display("FAIL grant_seq cycle%0d got=%b exp=%b", c, grant_a, exp_g[c]); end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got(k) !== exp_vec(k)) begin errors++; $display("FAIL grant_seq_model dut%0d got=%h exp=%h", k, got(k), exp_vec(k)); end
            end
        end
        rv = '0; rl = '0;
    endtask

    task automatic test_max_burst();
        int nb = 0;
        int drop_at = -1;
        do_reset();
        rv = 3'b100; rl = 3'b000;
        for (int c = 0; c < 12; c++) begin
            rand_pix();
            tick();
            if (plot_b && drop_at < 0) nb++;
            if (c > 0 && grant_b == 3'b000 && drop_at < 0) begin
                drop_at = c;
                checks++;
                if (nb !== 4 || c !== 4) begin errors++; $display("FAIL burst_release got=%0d plots at cycle %0d exp=4 at cycle 4", nb, c); end
            end
            if (drop_at >= 0 && c == drop_at + 1) begin
                checks++;
                if (grant_b !== 3'b100) begin errors++; $display("FAIL burst_regrant got=%b exp=100", grant_b); end
            end
            checks++;
            if (grant_a !== 3'b100) begin errors++; $display("FAIL burst_unlimited cycle%0d got=%b exp=100", c, grant_a); end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got(k) !== exp_vec(k)) begin errors++; $display("FAIL burst_model dut%0d got=%h exp=%h", k, got(k), exp_vec(k)); end
            end
        end
        checks++;
        if (drop_at < 0) begin errors++; $display("FAIL burst_timeout got=no release exp=release"); end
        rv = '0;
    endtask

    task automatic test_bounds();
        int tx [3] = '{160, 159, 159};
        int ty [3] = '{5, 119, 120};
        bit tp [3] = '{0, 1, 0};
        do_reset();
        for (int t = 0; t < 3; t++) begin
            rv = 3'b001; rl = 3'b001; set_pix(0, tx[t], ty[t], 24'h00FF00);
            tick(); tick();
            rv = '0; rl = '0;
            checks++;
            if (plot_a !== tp[t] || x_a !== 8'(tx[t]) || y_a !== 8'(ty[t])) begin
                errors++; $display("FAIL bounds%0d got=plot %b x %0d y %0d exp=plot %b x %0d y %0d", t, plot_a, x_a, y_a, tp[t], tx[t], ty[t]);
            end
            tick();
            checks++;
            if (x_a !== 8'(tx[t]) || plot_a !== 1'b0) begin errors++; $display("FAIL bounds_hold%0d got=x %0d plot %b exp=x %0d plot 0", t, x_a, plot_a, tx[t]); end
        end
    endtask

    task automatic test_stall_reset();
        do_reset();
        rv = 3'b001; rl = 3'b000; rand_pix();
        tick(); tick(); tick();
        rv = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (plot_a !== 1'b0 || grant_a !== 3'b001) begin errors++; $display("FAIL stall cycle%0d got=plot %b grant %b exp=plot 0 grant 001", c, plot_a, grant_a); end
        end
        rv = 3'b001; resetn = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (got(k) !== 47'd0) begin errors++; $display("FAIL stall_reset dut%0d got=%h exp=0", k, got(k)); end
        end
        resetn = 1'b1; rv = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            resetn = $urandom_range(0, 63) != 0;
            rv = 3'($urandom);
            rl = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            for (int i = 0; i < N; i++) set_pix(i, $urandom_range(0, 170), $urandom_range(0, 125), 24'($urandom));
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (got(k) !== exp_vec(k)) begin errors++; $display("FAIL random c%0d dut%0d got=%h exp=%h", c, k, got(k), exp_vec(k)); end
            end
        end
        resetn = 1'b1; rv = '0; rl = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fixed_priority();
        test_grant_seq();
        test_max_burst();
        test_bounds();
        test_stall_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
